tm1637_seq_ctrl: RTL



---
 rtl/tm1637_seq_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/tm1637_seq_ctrl.sv
// tm1637_seq_ctrl: drives the three-frame TM1637 display update through a start/done serial master
module tm1637_seq_ctrl #(
    parameter int unsigned MAX_RETRIES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned GAP_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        update,
    input  logic [15:0] digit_hex,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    input  logic [2:0]  brightness,
    input  logic        display_on,
    output logic        m_start,
    output logic [7:0]  m_data_array [0:7],
    output logic [2:0]  m_num_bytes,
    input  logic        m_busy,
    input  logic        m_done,
    input  logic        m_ack_error,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);
    typedef enum logic [2:0] {IDLE, LOAD, GAP, PULSE, WAIT, CHECK, FINISH} state_t;

    localparam logic [6:0]  HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRIES);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [32:0] TO_LAST   = {1'b0, 32'(TIMEOUT_CYCLES - 1)};

    state_t      state_q, state_d;
    logic        pending_q, pending_d, err_q, err_d, nack_q, nack_d, on_q, on_d;
    logic [1:0]  err_code_q, err_code_d, frame_q, frame_d;
    logic [2:0]  retry_q, retry_d, bright_q, bright_d, nbytes_q, nbytes_d;
    logic [31:0] gap_q, gap_d, to_q, to_d;
    logic [32:0] to_inc;
    logic [7:0]  seg_q [4];
    logic [7:0]  seg_d [4];
    logic [7:0]  data_q [8];
    logic [7:0]  data_d [8];

    function automatic logic [7:0] encode(input logic [3:0] hex, input logic point, input logic off);
        return off ? 8'h00 : {point, HEX[hex]};
    endfunction

    // Next state: snapshot on launch, frame loading, gap/timeout counting, retry and abort decisions
    always_comb begin
        state_d    = state_q;
        pending_d  = (state_q == IDLE) ? 1'b0 : (pending_q | update);
        err_d      = err_q;
        err_code_d = err_code_q;
        nack_d     = nack_q;
        on_d       = on_q;
        frame_d    = frame_q;
        retry_d    = retry_q;
        bright_d   = bright_q;
        nbytes_d   = nbytes_q;
        gap_d      = gap_q;
        to_d       = to_q;
        seg_d      = seg_q;
        data_d     = data_q;
        to_inc     = {1'b0, to_q} + 33'd1;
        case (state_q)
            IDLE: if (update || pending_q) begin
                state_d    = LOAD;
                err_d      = 1'b0;
                err_code_d = 2'b00;
                frame_d    = 2'd0;
                retry_d    = 3'd0;
                bright_d   = brightness;
                on_d       = display_on;
                for (int i = 0; i < 4; i++) seg_d[i] = encode(digit_hex[4*i +: 4], dp[i], blank[i]);
            end
            LOAD: begin
                data_d    = '{default: 8'h00};
                data_d[0] = (frame_q == 2'd0) ? 8'h40 : (frame_q == 2'd1) ? 8'hC0 :
                            (on_q ? {5'b10001, bright_q} : 8'h80);
                if (frame_q == 2'd1) for (int i = 0; i < 4; i++) data_d[i+1] = seg_q[i];
                nbytes_d  = (frame_q == 2'd1) ? 3'd5 : 3'd1;
                gap_d     = '0;
                state_d   = GAP;
            end
            GAP: begin
                gap_d = m_busy ? '0 : gap_q + 32'd1;
                if (!m_busy && gap_q == GAP_LAST) state_d = PULSE;
            end
            PULSE: begin
                to_d    = '0;
                state_d = WAIT;
            end
            WAIT: if (m_done) begin
                nack_d  = m_ack_error;
                state_d = CHECK;
            end else if (to_inc >= TO_LAST) begin
                err_d      = 1'b1;
                err_code_d = 2'b10;
                state_d    = FINISH;
            end else begin
                to_d = (&to_q) ? to_q : to_inc[31:0];
            end
            CHECK: begin
                state_d = LOAD;
                if (!nack_q && frame_q != 2'd2) begin
                    frame_d = frame_q + 2'd1;
                    retry_d = 3'd0;
                end else if (!nack_q) begin
                    state_d = FINISH;
                end else if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 3'd1;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                    state_d    = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registers; reset abandons any frame in flight and returns to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            nack_q     <= 1'b0;
            on_q       <= 1'b0;
            frame_q    <= 2'd0;
            retry_q    <= 3'd0;
            bright_q   <= 3'd0;
            nbytes_q   <= 3'd0;
            gap_q      <= '0;
            to_q       <= '0;
            seg_q      <= '{default: 8'h00};
            data_q     <= '{default: 8'h00};
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            nack_q     <= nack_d;
            on_q       <= on_d;
            frame_q    <= frame_d;
            retry_q    <= retry_d;
            bright_q   <= bright_d;
            nbytes_q   <= nbytes_d;
            gap_q      <= gap_d;
            to_q       <= to_d;
            seg_q      <= seg_d;
            data_q     <= data_d;
        end
    end

    assign m_start      = (state_q == PULSE);
    assign m_data_array = data_q;
    assign m_num_bytes  = nbytes_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FINISH);
    assign err          = err_q;
    assign err_code     = err_code_q;
endmodule
